// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges the cache's single-transfer line port to a
// multi-beat burst memory bus. One line transfer is in flight at a time.
//
// Ports
//   clk, rst               single clock, synchronous active-high reset
//   line_i / line_o        line to write / assembled read line (cache side)
//   address_i              line address from the cache
//   read_i / write_i       cache line requests, held until resp_o
//   resp_o                 one-cycle completion pulse to the cache
//   burst_i / burst_o      read beat from memory / write beat to memory
//   address_o              aligned line address presented for the whole burst
//   read_o / write_o       burst requests to memory
//   resp_i                 memory beat strobe, one beat per high cycle
module cacheline_adaptor #(
  parameter int unsigned s_line    = 256,
  parameter int unsigned s_burst   = 64,
  parameter int unsigned s_offset  = 5,
  parameter int unsigned num_beats = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned cnt_w = $clog2(num_beats);
  localparam logic [31:0] align_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [s_line-1:0]  line_buf, line_buf_next;
  logic [31:0]        addr_reg, addr_next;
  logic [cnt_w-1:0]   cnt, cnt_next;
  logic               last_beat;

  assign last_beat = (cnt == cnt_w'(num_beats - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      line_buf <= '0;
      addr_reg <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_next;
      line_buf <= line_buf_next;
      addr_reg <= addr_next;
      cnt      <= cnt_next;
    end
  end

  // Next-state and datapath update; gaps in resp_i simply hold everything
  always_comb begin
    state_next    = state;
    line_buf_next = line_buf;
    addr_next     = addr_reg;
    cnt_next      = cnt;
    case (state)
      IDLE: begin
        // write wins when both requests are present
        if (write_i) begin
          line_buf_next = line_i;
          addr_next     = address_i & align_mask;
          cnt_next      = '0;
          state_next    = WRITE;
        end else if (read_i) begin
          addr_next  = address_i & align_mask;
          cnt_next   = '0;
          state_next = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          line_buf_next[s_burst * 32'(cnt) +: s_burst] = burst_i;
          cnt_next = cnt + cnt_w'(1);
          if (last_beat) state_next = DONE;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_next = cnt + cnt_w'(1);
          if (last_beat) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory and cache outputs are decodes or muxes of registered state only
  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign address_o = addr_reg;
  assign line_o    = line_buf;
  assign burst_o   = line_buf[s_burst * 32'(cnt) +: s_burst];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Testbench for cacheline_adaptor: randomized transactions checked against a
// transaction-level model (line = beats in order, beat k visible while k beats
// have been consumed, one resp_o pulse after the final beat).
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_cmp;
  int n_fail;
  logic [255:0] last_line;
  logic [31:0]  last_addr;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One line transaction. pat gives resp_i for the first pat_len busy cycles,
  // random afterwards. fixed_beats uses 0x1111.., 0x2222.., ... as read beats.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input bit drop, input logic [15:0] pat, input int pat_len,
                         input bit fixed_beats, output int active_cycles);
    logic [63:0]  beats [4];
    logic [255:0] wline;
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    logic [63:0]  rep;
    int           done_beats;
    int           cyc;
    bit           r;
    bit           is_wr;
    rep = 64'h1111_1111_1111_1111;
    for (int k = 0; k < 4; k++)
      beats[k] = fixed_beats ? rep * 64'(k + 1) : {$urandom, $urandom};
    for (int k = 0; k < 8; k++) wline[32*k +: 32] = $urandom;
    is_wr    = wr;
    exp_line = is_wr ? wline : {beats[3], beats[2], beats[1], beats[0]};
    exp_addr = addr & ~32'h1f;
    line_i    = wline;
    address_i = addr;
    write_i   = wr;
    read_i    = rd;
    resp_i    = 1'b0;
    step();
    done_beats    = 0;
    cyc           = 0;
    active_cycles = 0;
    while (done_beats < 4 && cyc < 200) begin
      r = (cyc < pat_len) ? pat[cyc] : ($urandom_range(0, 2) != 0);
      n_cmp++;
      if (read_o !== !is_wr || write_o !== is_wr || resp_o !== 1'b0 || address_o !== exp_addr) begin
        n_fail++;
        $display("FAIL busy_ctrl cyc=%0d: got rd=%b wr=%b resp=%b addr=%h, required rd=%b wr=%b resp=0 addr=%h",
                 cyc, read_o, write_o, resp_o, address_o, !is_wr, is_wr, exp_addr);
      end
      if (is_wr) begin
        n_cmp++;
        if (burst_o !== wline[64*done_beats +: 64]) begin
          n_fail++;
          $display("FAIL burst_o cyc=%0d beat=%0d: got %h, required %h",
                   cyc, done_beats, burst_o, wline[64*done_beats +: 64]);
        end
      end
      if (read_o || write_o) active_cycles++;
      resp_i  = r;
      burst_i = r ? beats[done_beats] : {$urandom, $urandom};
      if (drop && done_beats >= 2) begin
        read_i  = 1'b0;
        write_i = 1'b0;
      end
      step();
      if (r) done_beats++;
      cyc++;
    end
    resp_i = 1'b0;
    if (done_beats < 4) begin
      n_fail++;
      $display("FAIL timeout: got %0d beats, required 4", done_beats);
    end
    // Completion cycle
    n_cmp++;
    if (resp_o !== 1'b1 || read_o !== 1'b0 || write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL done_ctrl: got resp=%b rd=%b wr=%b, required resp=1 rd=0 wr=0", resp_o, read_o, write_o);
    end
    n_cmp++;
    if (line_o !== exp_line) begin
      n_fail++;
      $display("FAIL line_done: got %h, required %h", line_o, exp_line);
    end
    read_i  = 1'b0;
    write_i = 1'b0;
    step();
    n_cmp++;
    if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || line_o !== exp_line) begin
      n_fail++;
      $display("FAIL after_done: got resp=%b rd=%b wr=%b line=%h, required 0 0 0 %h",
               resp_o, read_o, write_o, line_o, exp_line);
    end
    last_line = exp_line;
    last_addr = exp_addr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || burst_o !== 64'h0 ||
        address_o !== 32'h0 || line_o !== 256'h0) begin
      n_fail++;
      $display("FAIL reset_state: got rd=%b wr=%b resp=%b burst=%h addr=%h line=%h, required all 0",
               read_o, write_o, resp_o, burst_o, address_o, line_o);
    end
  endtask

  task automatic test_read_directed();
    int act;
    run_txn(1'b0, 1'b1, 32'h0000_1234, 1'b0, 16'b11110, 5, 1'b1, act);
    n_cmp++;
    if (act !== 5) begin
      n_fail++;
      $display("FAIL read_o_cycles: got %0d, required 5", act);
    end
    n_cmp++;
    if (address_o !== 32'h0000_1220) begin
      n_fail++;
      $display("FAIL read_addr: got %h, required 00001220", address_o);
    end
  endtask

  task automatic test_write_gaps();
    int act;
    run_txn(1'b1, 1'b0, $urandom, 1'b0, 16'b1011001, 7, 1'b0, act);
    n_cmp++;
    if (act !== 7) begin
      n_fail++;
      $display("FAIL write_o_cycles: got %0d, required 7", act);
    end
  endtask

  task automatic test_simultaneous();
    int act;
    run_txn(1'b1, 1'b1, $urandom, 1'b0, 16'h0, 0, 1'b0, act);
  endtask

  task automatic test_reset_mid_read();
    int act;
    address_i = 32'hABCD_EF7F;
    read_i    = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      step();
    end
    rst = 1'b1;
    step();
    rst     = 1'b0;
    read_i  = 1'b0;
    resp_i  = 1'b0;
    n_cmp++;
    if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || burst_o !== 64'h0 ||
        address_o !== 32'h0 || line_o !== 256'h0) begin
      n_fail++;
      $display("FAIL reset_mid_read: got rd=%b wr=%b resp=%b burst=%h addr=%h line=%h, required all 0",
               read_o, write_o, resp_o, burst_o, address_o, line_o);
    end
    step();
    n_cmp++;
    if (read_o !== 1'b0 || resp_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rd=%b resp=%b, required 0 0", read_o, resp_o);
    end
    run_txn(1'b0, 1'b1, $urandom, 1'b0, 16'h0, 0, 1'b0, act);
  endtask

  task automatic test_spurious_resp();
    int act;
    read_i  = 1'b0;
    write_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      step();
      n_cmp++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 ||
          line_o !== last_line || address_o !== last_addr) begin
        n_fail++;
        $display("FAIL spurious_resp k=%0d: got rd=%b wr=%b resp=%b addr=%h, required 0 0 0 %h",
                 k, read_o, write_o, resp_o, address_o, last_addr);
      end
    end
    resp_i = 1'b0;
    step();
    run_txn(1'b0, 1'b1, $urandom, 1'b0, 16'h0, 0, 1'b0, act);
  endtask

  task automatic test_drop_mid_burst();
    int act;
    run_txn(1'b0, 1'b1, $urandom, 1'b1, 16'h0, 0, 1'b0, act);
    run_txn(1'b1, 1'b0, $urandom, 1'b1, 16'h0, 0, 1'b0, act);
  endtask

  task automatic test_random();
    int act;
    bit wr;
    bit rd;
    for (int t = 0; t < 30; t++) begin
      wr = ($urandom_range(0, 1) == 1);
      rd = !wr || ($urandom_range(0, 3) == 0);
      run_txn(wr, rd, $urandom, ($urandom_range(0, 3) == 0), 16'h0, 0, 1'b0, act);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    last_line = '0;
    last_addr = '0;
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    test_reset();
    test_read_directed();
    test_write_gaps();
    test_simultaneous();
    test_reset_mid_read();
    test_spurious_resp();
    test_drop_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
